// File: rtl/req_latch_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Each bit is synchronised on its own; there is no cross-bit coherence.
module sync2 #(
  parameter int unsigned w = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);

  logic [w-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/req_latch.sv
// Request capture stage: synchronise, detect rising edges, hold sticky pending bits
// until acknowledged by index, and flag events lost on an already-pending bit.
module req_latch #(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [m-1:0] req,
  input  logic [m-1:0] mask,
  input  logic         ack,
  input  logic [n-1:0] ack_idx,
  input  logic         ovf_clr,
  output logic [m-1:0] pend,
  output logic         valid,
  output logic         ovf
);

  logic [m-1:0] s2;
  logic [m-1:0] h;
  logic [m-1:0] pending;
  logic [m-1:0] e;
  logic [m-1:0] clr;
  logic [m-1:0] pending_nxt;
  logic         lost;

  sync2 #(.w(m)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req),
    .q     (s2)
  );

  // Masking is purely an output view; masked bits still latch.
  assign pend  = pending & ~mask;
  assign valid = |pend;
  assign e     = s2 & ~h;

  // At most one bit is cleared; out-of-range, idle or masked indices match nothing.
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(m); i++) begin
      if (ack && (ack_idx == n'(i)) && pend[i]) begin
        clr[i] = 1'b1;
      end
    end
  end

  // A new event wins over a same-cycle clear, and that case loses nothing.
  assign lost        = |(e & pending & ~clr);
  assign pending_nxt = (pending & ~clr) | e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      h       <= s2;
      pending <= pending_nxt;
      if (lost) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
